// File: rtl/audio_pkg.sv
// Shared types for the note sequencer: generator-select codes, the
// step-word layout and the sequencer state encoding.
package audio_pkg;

    localparam int GEN_SEL_W = 3;
    localparam int VOL4_W    = 4;
    localparam int DUR_W     = 8;
    localparam int FREQ_W    = 16;
    localparam int VOL_W     = 8;

    localparam logic [GEN_SEL_W-1:0] GEN_SQUARE   = 3'd0;
    localparam logic [GEN_SEL_W-1:0] GEN_SAW      = 3'd1;
    localparam logic [GEN_SEL_W-1:0] GEN_SAW_INV  = 3'd2;
    localparam logic [GEN_SEL_W-1:0] GEN_TRIANGLE = 3'd3;
    localparam logic [GEN_SEL_W-1:0] GEN_SINE     = 3'd4;
    localparam logic [GEN_SEL_W-1:0] GEN_NOISE    = 3'd5;

    typedef struct packed {
        logic [GEN_SEL_W-1:0] gen_sel;   // [31:29]
        logic                 last;      // [28]
        logic [VOL4_W-1:0]    vol4;      // [27:24]
        logic [DUR_W-1:0]     dur;       // [23:16]
        logic [FREQ_W-1:0]    freq;      // [15:0]
    } step_word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } seq_state_e;

endpackage

// File: rtl/audio_step_mem.sv
// Pattern storage: STEPS x 32-bit register array, no reset.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o
// combinational read port.
module audio_step_mem
    import audio_pkg::*;
#(
    parameter int STEPS = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(STEPS)-1:0] waddr_i,
    input  step_word_t               wdata_i,
    input  logic [$clog2(STEPS)-1:0] raddr_i,
    output step_word_t               rdata_o
);

    step_word_t mem_q [STEPS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/audio_note_sequencer.sv
// Walks a programmed note pattern and drives one audio channel's
// enable / generator-select / frequency / volume inputs.
// Ports: clk_i, rst_i (sync, active-high); cfg_we_i/cfg_addr_i/cfg_data_i
// step-memory write; start_i/stop_i pulses, loop_i level; busy_o, step_o
// status; ch_en_o, ch_gen_sel_o, ch_freq_o, ch_volume_o channel drive.
// Build option: AUDIO_NOTE_SEQ_ENVELOPE_EN adds a linear attack envelope.
//
// state  | meaning
// S_IDLE | stopped, all channel outputs 0
// S_LOAD | one cycle: fetch memory[step], register new outputs
// S_PLAY | count ticks until the step's duration expires
module audio_note_sequencer
    import audio_pkg::*;
#(
    parameter int          STEPS    = 16,
    parameter int          TICK_DIV = 1000,
    parameter logic [7:0]  ENV_STEP = 8'd16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_we_i,
    input  logic [$clog2(STEPS)-1:0] cfg_addr_i,
    input  logic [31:0]              cfg_data_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic                     busy_o,
    output logic [$clog2(STEPS)-1:0] step_o,
    output logic                     ch_en_o,
    output logic [2:0]               ch_gen_sel_o,
    output logic [15:0]              ch_freq_o,
    output logic [7:0]               ch_volume_o
);

    localparam int AW = $clog2(STEPS);
    localparam int PW = $clog2(TICK_DIV);

    seq_state_e           state_q, state_d;
    logic [AW-1:0]        step_q, step_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic                 last_q, last_d;
    logic                 en_q, en_d;
    logic [GEN_SEL_W-1:0] gen_q, gen_d;
    logic [FREQ_W-1:0]    freq_q, freq_d;
    logic [VOL_W-1:0]     vol_q, vol_d;

    step_word_t rd_word;
    logic       rest;
    logic       tick;
    logic       final_tick;
    logic       pat_end;

`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
    logic [VOL_W-1:0] tgt_q, tgt_d;
    logic [VOL_W:0]   env_sum;
    assign env_sum = {1'b0, vol_q} + {1'b0, ENV_STEP};
`endif

    audio_step_mem #(.STEPS(STEPS)) u_mem (
        .clk_i   (clk_i),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wdata_i (step_word_t'(cfg_data_i)),
        .raddr_i (step_q),
        .rdata_o (rd_word)
    );

    assign rest       = (rd_word.vol4 == '0);
    assign tick       = (state_q == S_PLAY) && (presc_q == PW'(TICK_DIV - 1));
    assign final_tick = tick && (dur_q == 8'd1);
    // last flag is latched at LOAD so rewriting the playing step cannot end it early
    assign pat_end    = last_q || (step_q == AW'(STEPS - 1));

    // state register + datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            presc_q <= '0;
            dur_q   <= '0;
            last_q  <= 1'b0;
            en_q    <= 1'b0;
            gen_q   <= '0;
            freq_q  <= '0;
            vol_q   <= '0;
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
            tgt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            last_q  <= last_d;
            en_q    <= en_d;
            gen_q   <= gen_d;
            freq_q  <= freq_d;
            vol_q   <= vol_d;
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
            tgt_q   <= tgt_d;
`endif
        end
    end

    // next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: state_d = S_PLAY;
            S_PLAY: begin
                if (final_tick) begin
                    state_d = (pat_end && !loop_i) ? S_IDLE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (stop_i) state_d = S_IDLE;
    end

    // datapath / registered-output next values
    always_comb begin
        step_d  = step_q;
        presc_d = presc_q;
        dur_d   = dur_q;
        last_d  = last_q;
        en_d    = en_q;
        gen_d   = gen_q;
        freq_d  = freq_q;
        vol_d   = vol_q;
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
        tgt_d   = tgt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                step_d  = '0;
                presc_d = '0;
            end
            S_LOAD: begin
                gen_d   = rd_word.gen_sel;
                freq_d  = rd_word.freq;
                en_d    = !rest;
                last_d  = rd_word.last;
                dur_d   = (rd_word.dur == '0) ? 8'd1 : rd_word.dur;
                presc_d = '0;
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
                vol_d   = '0;
                tgt_d   = rest ? 8'h00 : {rd_word.vol4, rd_word.vol4};
`else
                vol_d   = rest ? 8'h00 : {rd_word.vol4, rd_word.vol4};
`endif
            end
            S_PLAY: begin
                if (tick) begin
                    presc_d = '0;
                    dur_d   = dur_q - 8'd1;
                    if (final_tick) begin
                        step_d = pat_end ? '0 : step_q + AW'(1);
                    end else begin
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
                        vol_d = (env_sum > {1'b0, tgt_q}) ? tgt_q : env_sum[VOL_W-1:0];
`endif
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: ;
        endcase
        // entering IDLE (stop or end of pattern) zeroes everything on that edge
        if (state_d == S_IDLE) begin
            step_d  = '0;
            presc_d = '0;
            dur_d   = '0;
            last_d  = 1'b0;
            en_d    = 1'b0;
            gen_d   = '0;
            freq_d  = '0;
            vol_d   = '0;
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
            tgt_d   = '0;
`endif
        end
    end

    // outputs
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        step_o       = step_q;
        ch_en_o      = en_q;
        ch_gen_sel_o = gen_q;
        ch_freq_o    = freq_q;
        ch_volume_o  = vol_q;
    end

endmodule

// File: tb/tb_audio_note_sequencer.sv
module tb_audio_note_sequencer;

    localparam int STEPS    = 4;
    localparam int TICK_DIV = 4;
`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
    localparam logic [7:0] ENV = 8'h40;
    localparam bit ENV_ON = 1'b1;
`else
    localparam logic [7:0] ENV = 8'd16;
    localparam bit ENV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        start, stop, loop_en;
    logic        busy;
    logic [1:0]  step;
    logic        ch_en;
    logic [2:0]  ch_sel;
    logic [15:0] ch_freq;
    logic [7:0]  ch_vol;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    audio_note_sequencer #(
        .STEPS    (STEPS),
        .TICK_DIV (TICK_DIV),
        .ENV_STEP (ENV)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .start_i      (start),
        .stop_i       (stop),
        .loop_i       (loop_en),
        .busy_o       (busy),
        .step_o       (step),
        .ch_en_o      (ch_en),
        .ch_gen_sel_o (ch_sel),
        .ch_freq_o    (ch_freq),
        .ch_volume_o  (ch_vol)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step_clk();
        cfg_we   = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk_eq({tag, ".busy"}, busy, 0);
        chk_eq({tag, ".step"}, step, 0);
        chk_eq({tag, ".en"},   ch_en, 0);
        chk_eq({tag, ".sel"},  ch_sel, 0);
        chk_eq({tag, ".freq"}, ch_freq, 0);
        chk_eq({tag, ".vol"},  ch_vol, 0);
    endtask

    // start pulse: LOAD cycle, then position at first PLAY cycle of step 0
    task automatic do_start();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        chk_eq("start.busy", busy, 1);
        chk_eq("start.en_in_load", ch_en, 0);
        step_clk();
    endtask

    // checks n consecutive cycles of one step; stp_end is step_o in the last
    // cycle (differs when that cycle is the following LOAD)
    task automatic expect_step(input string tag, input int n, input int dur,
                               input int en, input int sel, input int freq,
                               input int tgt, input int stp, input int stp_end);
        int k, v;
        for (int i = 0; i < n; i++) begin
            if (ENV_ON) begin
                k = i / TICK_DIV;
                if (k > dur - 1) k = dur - 1;
                v = k * int'(ENV);
                if (v > tgt) v = tgt;
            end else begin
                v = tgt;
            end
            chk_eq({tag, ".busy"}, busy, 1);
            chk_eq({tag, ".step"}, step, (i == n - 1) ? stp_end : stp);
            chk_eq({tag, ".en"},   ch_en, en);
            chk_eq({tag, ".sel"},  ch_sel, sel);
            chk_eq({tag, ".freq"}, ch_freq, freq);
            chk_eq({tag, ".vol"},  ch_vol, v);
            step_clk();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; loop_en = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) step_clk();
        rst = 1'b0; start = 1'b0;
        repeat (20) step_clk();
        check_idle("reset");

        // two-step pattern, no loop
        wr(2'd0, 32'h8F02_0100);   // sine, vol F, dur 2, freq 0x100
        wr(2'd1, 32'h1801_0200);   // square, last, vol 8, dur 1, freq 0x200
        do_start();
        expect_step("s0", 9, 2, 1, 4, 16'h0100, 8'hFF, 0, 1);
        expect_step("s1", 4, 1, 1, 0, 16'h0200, 8'h88, 1, 1);
        check_idle("end");

        // looping: 14-cycle period, no idle gap
        loop_en = 1'b1;
        do_start();
        for (int r = 0; r < 2; r++) begin
            expect_step("l0", 9, 2, 1, 4, 16'h0100, 8'hFF, 0, 1);
            expect_step("l1", 5, 1, 1, 0, 16'h0200, 8'h88, 1, 0);
        end
        expect_step("l2", 3, 2, 1, 4, 16'h0100, 8'hFF, 0, 0);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        loop_en = 1'b0;
        check_idle("stop_mid");

        // stop together with start in IDLE
        start = 1'b1; stop = 1'b1;
        step_clk();
        start = 1'b0; stop = 1'b0;
        check_idle("stop_start");
        step_clk();
        check_idle("stop_start2");

        // rest step (vol 0, dur 0) between two notes; start held while busy
        wr(2'd0, 32'h8F01_0100);
        wr(2'd1, 32'h2000_0300);   // saw, rest, dur 0, freq 0x300
        wr(2'd2, 32'h1801_0200);
        do_start();
        start = 1'b1;
        expect_step("r0", 5, 1, 1, 4, 16'h0100, 8'hFF, 0, 1);
        start = 1'b0;
        expect_step("r1", 5, 1, 0, 1, 16'h0300, 8'h00, 1, 2);
        expect_step("r2", 4, 1, 1, 0, 16'h0200, 8'h88, 2, 2);
        check_idle("rest_end");

`ifdef AUDIO_NOTE_SEQ_ENVELOPE_EN
        // attack envelope: 0x00,0x40,0x80,0xC0,0xFF each held one tick
        wr(2'd0, 32'h1F05_0400);
        do_start();
        expect_step("env", 20, 5, 1, 0, 16'h0400, 8'hFF, 0, 0);
        check_idle("env_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
